// File: rtl/bip_result_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : bip_result_tx_if
// Brief    : Processor/UART handshake bundle for the BIP result transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface bip_result_tx_if #(
    parameter int NB_ACC = 16
);
    logic              start_bip;
    logic              wr_uart;
    logic [NB_ACC-1:0] acc;
    logic              tx_done_tick;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              busy;
    logic              frame_done;
    logic              overrun;

    // master: the result transmitter itself
    modport master (
        input  start_bip, wr_uart, acc, tx_done_tick,
        output tx_start, tx_data, busy, frame_done, overrun
    );

    // slave: processor and UART side
    modport slave (
        output start_bip, wr_uart, acc, tx_done_tick,
        input  tx_start, tx_data, busy, frame_done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/bip_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : bip_result_tx
// Brief    : Snapshots the BIP accumulator and cycle count on a result event
//            and sends them as a 5-byte frame (A5, acc, cnt) over a UART.
// Revision : 1.0 - initial release
// ============================================================================
module bip_result_tx #(
    parameter int NB_ACC = 16,
    parameter int NB_CNT = 16
) (
    input  wire                     clk,
    input  wire                     reset,
    bip_result_tx_if.master         bus
);
    localparam logic [7:0]        c_SYNC     = 8'hA5;
    localparam logic [2:0]        c_LAST_IDX = 3'd4;
    localparam logic [NB_CNT-1:0] c_CNT_MAX  = {NB_CNT{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic              r_start_q;
    logic              r_wr_q;
    logic              r_halt;
    logic              r_overrun;
    logic [NB_CNT-1:0] r_cnt;
    logic [NB_CNT-1:0] r_cnt_snap;
    logic [NB_ACC-1:0] r_acc_snap;

    logic              w_start_rise;
    logic              w_result;
    logic              w_accept;
    logic              w_halted;
    logic [NB_CNT-1:0] w_cnt_now;
    logic              w_tx_start;
    logic [7:0]        w_tx_data;
    logic              w_busy;
    logic              w_frame_done;

    assign w_start_rise = bus.start_bip & ~r_start_q;
    assign w_result     = bus.wr_uart & ~r_wr_q;
    assign w_accept     = w_result && (r_state == IDLE);
    // A start edge restarts the count from zero within the same cycle
    assign w_cnt_now    = w_start_rise ? '0 : r_cnt;
    assign w_halted     = r_halt && !w_start_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_q  <= 1'b0;
            r_wr_q     <= 1'b0;
            r_halt     <= 1'b0;
            r_overrun  <= 1'b0;
            r_cnt      <= '0;
            r_cnt_snap <= '0;
            r_acc_snap <= '0;
        end else begin
            r_start_q <= bus.start_bip;
            r_wr_q    <= bus.wr_uart;
            if (w_accept) begin
                r_acc_snap <= bus.acc;
                r_cnt_snap <= w_cnt_now;
                r_cnt      <= w_cnt_now;
                r_halt     <= 1'b1;
            end else begin
                if (w_start_rise) begin
                    r_halt <= 1'b0;
                end
                if (bus.start_bip && !w_halted && (w_cnt_now != c_CNT_MAX)) begin
                    r_cnt <= w_cnt_now + NB_CNT'(1);
                end else begin
                    r_cnt <= w_cnt_now;
                end
            end
            if (w_result && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_tx_start   = 1'b0;
        w_busy       = 1'b1;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_result) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = 3'd0;
                end
            end
            SEND: begin
                w_tx_start  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.tx_done_tick) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = SEND;
                    end
                end
            end
            DONE: begin
                w_frame_done = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Byte index is frozen across SEND/WAIT, so the data holds until the tick
    always_comb begin
        w_tx_data = 8'h00;
        if (r_state != IDLE) begin
            case (r_idx)
                3'd0:    w_tx_data = c_SYNC;
                3'd1:    w_tx_data = r_acc_snap[NB_ACC-1 -: 8];
                3'd2:    w_tx_data = r_acc_snap[7:0];
                3'd3:    w_tx_data = r_cnt_snap[NB_CNT-1 -: 8];
                3'd4:    w_tx_data = r_cnt_snap[7:0];
                default: w_tx_data = 8'h00;
            endcase
        end
    end

    assign bus.tx_start   = w_tx_start;
    assign bus.tx_data    = w_tx_data;
    assign bus.busy       = w_busy;
    assign bus.frame_done = w_frame_done;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire
